// File: rtl/trigger_gen.sv
// trigger_gen -- programmable trigger pulse-train generator (aclk domain).
//
// A rising edge of the already-synchronized start level latches the pulse
// shape and launches a train of pulses on trigger. Each pulse is W cycles
// high and L cycles low. The train holds NREP_REG pulses, or runs
// continuously when NREP_REG is 0. A low level on start aborts the train.
//
// Ports:
//   aclk        clock
//   aresetn     asynchronous active-low reset
//   start       start level, synchronous to aclk
//   trigger     registered pulse output
//   busy        registered, high while a train is running
//   WIDTH_REG   high-phase length in cycles; 0 is treated as 1
//   PERIOD_REG  rising-edge-to-rising-edge distance; raised to at least W+1
//   NREP_REG    pulse count; 0 means continuous
//   COUNT_REG   pulses emitted since the last start edge, saturating
//
// Build option: define TRIGGER_GEN_COUNT_EN to implement the COUNT_REG
// pulse counter. When the macro is undefined, COUNT_REG is tied to 0.

module trigger_gen #(
    parameter int N = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         start,
    output logic         trigger,
    output logic         busy,
    input  logic [N-1:0] WIDTH_REG,
    input  logic [N-1:0] PERIOD_REG,
    input  logic [N-1:0] NREP_REG,
    output logic [31:0]  COUNT_REG
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state;
    logic         start_d;
    logic         start_re;
    logic         start_re_q;
    logic [N-1:0] phase;
    logic [N-1:0] rep;
    logic [N-1:0] w_lat;
    logic [N-1:0] l_lat;
    logic         cont_lat;

    // Shape derived from the live registers. It is only sampled on the
    // launch edge.
    logic [N-1:0] w_eff;
    logic [N:0]   w_p1;
    logic [N:0]   p_ext;
    logic [N-1:0] p_eff;
    logic [N-1:0] l_eff;

    assign start_re = start & ~start_d;

    assign w_eff = (WIDTH_REG == '0) ? ONE : WIDTH_REG;
    assign w_p1  = {1'b0, w_eff} + (N+1)'(1);
    assign p_ext = ({1'b0, PERIOD_REG} > w_p1) ? {1'b0, PERIOD_REG} : w_p1;
    assign p_eff = p_ext[N] ? '1 : p_ext[N-1:0];
    // Only W = 2^N-1 can saturate P down to W. Keep one low cycle in that
    // case so that pulses stay distinguishable.
    assign l_eff = (p_eff > w_eff) ? (p_eff - w_eff) : ONE;

    // start_re is registered. Both the launch and the abort (via start_d)
    // then act one edge after start is sampled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_d    <= 1'b0;
            start_re_q <= 1'b0;
        end else begin
            start_d    <= start;
            start_re_q <= start_re;
        end
    end

    logic launch;    // IDLE -> HIGH
    logic relaunch;  // LOW  -> HIGH
    assign launch   = (state == IDLE) && start_re_q;
    assign relaunch = (state == LOW) && start_d && (phase == ONE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            trigger  <= 1'b0;
            busy     <= 1'b0;
            phase    <= '0;
            rep      <= '0;
            w_lat    <= ONE;
            l_lat    <= ONE;
            cont_lat <= 1'b0;
        end else if (state != IDLE && !start_d) begin
            state   <= IDLE;
            trigger <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_re_q) begin
                        w_lat    <= w_eff;
                        l_lat    <= l_eff;
                        cont_lat <= (NREP_REG == '0);
                        phase    <= w_eff;
                        rep      <= NREP_REG;
                        state    <= HIGH;
                        trigger  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase == ONE) begin
                        trigger <= 1'b0;
                        if (!cont_lat && rep == ONE) begin
                            // Last pulse: no trailing low phase.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= LOW;
                            phase <= l_lat;
                            if (!cont_lat) rep <= rep - ONE;
                        end
                    end else begin
                        phase <= phase - ONE;
                    end
                end
                LOW: begin
                    if (phase == ONE) begin
                        state   <= HIGH;
                        phase   <= w_lat;
                        trigger <= 1'b1;
                    end else begin
                        phase <= phase - ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRIGGER_GEN_COUNT_EN
    logic [31:0] count;

    // Clear and first increment share the launch edge, so the first pulse
    // reads as 1.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            count <= '0;
        else if (launch)
            count <= 32'd1;
        else if (relaunch && count != '1)
            count <= count + 32'd1;
    end

    assign COUNT_REG = count;
`else
    assign COUNT_REG = '0;
`endif

endmodule
